// File: rtl/mul4_pkg.sv
// rtl/mul4_pkg.sv - shared types and constants for the mul4 fitness scorer
package mul4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_MUL,
        ST_CMP,
        ST_DONE
    } state_t;

    localparam int                LFSR_W      = 64;
    localparam logic [LFSR_W-1:0] LFSR_MASK   = 64'hD800_0000_0000_0000;
    localparam int                MUL_CYCLES  = 32;
    localparam int                VEC_BITS    = 64;
    localparam int                NUM_CORNERS = 4;

    // Corner vectors packed as {a[31:0], b[31:0]}
    localparam logic [63:0] CORNER_0 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CORNER_1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CORNER_2 = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] CORNER_3 = 64'h8000_0000_0000_0002;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    function automatic logic [63:0] corner_vec(input int idx);
        case (idx)
            0:       return CORNER_0;
            1:       return CORNER_1;
            2:       return CORNER_2;
            default: return CORNER_3;
        endcase
    endfunction

endpackage

// File: rtl/mul4_fitness_scorer_mul32.sv
// rtl/mul4_fitness_scorer_mul32.sv - 32x32 shift-add golden multiplier, one bit per cycle
module mul32_shift_add
    import mul4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid,
    output logic [63:0] product
);

    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [4:0]  cnt_q;
    logic        run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                product  <= '0;
                mcand_q  <= {32'h0, a};
                mplier_q <= b;
                cnt_q    <= '0;
                run_q    <= 1'b1;
            end else if (run_q) begin
                if (mplier_q[0]) begin
                    product <= product + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                    run_q <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// rtl/mul4_fitness_scorer.sv - candidate multiplier fitness scorer; MUL4_SCORER_CORNER_EN adds corner preamble
module mul4_fitness_scorer
    import mul4_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter int          SCORE_W     = 15,
    parameter logic [63:0] LFSR_SEED   = 64'h1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic [15:0]                          a1,
    output logic [15:0]                          a0,
    output logic [15:0]                          b1,
    output logic [15:0]                          b0,
    input  logic [15:0]                          y3,
    input  logic [15:0]                          y2,
    input  logic [15:0]                          y1,
    input  logic [15:0]                          y0,
    output logic                                 busy,
    output logic                                 done,
    output logic [SCORE_W-1:0]                   score,
    output logic [$clog2(NUM_VECTORS+1)-1:0]     vec_count,
    output logic                                 perfect
);

    localparam int                 VC_W          = $clog2(NUM_VECTORS + 1);
    localparam logic [63:0]        SEED_EFF      = (LFSR_SEED == 64'h0) ? 64'h1 : LFSR_SEED;
    localparam logic [VC_W:0]      LAST_COUNT    = (VC_W + 1)'(NUM_VECTORS);
    localparam logic [SCORE_W-1:0] PERFECT_SCORE = SCORE_W'(VEC_BITS * NUM_VECTORS);

    state_t             state_q, state_d;
    logic [63:0]        lfsr_q;
    logic [63:0]        lfsr_next;
    logic [63:0]        vec_next;
    logic               lfsr_adv;
    logic [4:0]         mul_cnt_q;
    logic [63:0]        golden;
    logic               mul_valid;
    logic [63:0]        y_word;
    logic [6:0]         match_bits;
    logic [SCORE_W-1:0] score_next;
    logic [VC_W:0]      vc_inc;
    logic               last_vec;
    logic               gen_load;

    assign lfsr_next = lfsr_step(lfsr_q);

`ifdef MUL4_SCORER_CORNER_EN
    logic use_corner;
    // The first vectors come from the fixed table and leave the LFSR untouched
    assign use_corner = (32'(vec_count) < NUM_CORNERS);
    assign vec_next   = use_corner ? corner_vec(32'(vec_count)) : lfsr_next;
    assign lfsr_adv   = !use_corner;
`else
    assign vec_next   = lfsr_next;
    assign lfsr_adv   = 1'b1;
`endif

    assign gen_load = (state_q == ST_GEN);

    mul32_shift_add u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gen_load),
        .a       (vec_next[63:32]),
        .b       (vec_next[31:0]),
        .valid   (mul_valid),
        .product (golden)
    );

    assign y_word = {y3, y2, y1, y0};

    always_comb begin
        match_bits = '0;
        for (int i = 0; i < VEC_BITS; i++) begin
            match_bits = match_bits + 7'(~(y_word[i] ^ golden[i]));
        end
    end

    assign score_next = score + SCORE_W'(match_bits);
    assign vc_inc     = {1'b0, vec_count} + (VC_W + 1)'(1);
    assign last_vec   = (vc_inc == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_GEN;
            end
            ST_GEN: begin
                busy    = 1'b1;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                busy = 1'b1;
                if (mul_cnt_q == 5'(MUL_CYCLES - 1)) state_d = ST_CMP;
            end
            ST_CMP: begin
                busy    = 1'b1;
                state_d = last_vec ? ST_DONE : ST_GEN;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q         <= SEED_EFF;
            {a1, a0, b1, b0} <= '0;
            mul_cnt_q      <= '0;
            score          <= '0;
            vec_count      <= '0;
            perfect        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lfsr_q    <= SEED_EFF;
                        score     <= '0;
                        vec_count <= '0;
                        perfect   <= 1'b0;
                    end
                end
                ST_GEN: begin
                    if (lfsr_adv) lfsr_q <= lfsr_next;
                    {a1, a0, b1, b0} <= vec_next;
                    mul_cnt_q        <= '0;
                end
                ST_MUL: begin
                    mul_cnt_q <= mul_cnt_q + 5'd1;
                end
                ST_CMP: begin
                    if (mul_valid) begin
                        score     <= score_next;
                        vec_count <= vc_inc[VC_W-1:0];
                        // Registered on the way into DONE so it is valid in the done cycle
                        if (last_vec) perfect <= (score_next == PERFECT_SCORE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul4_fitness_scorer.md
# mul4_fitness_scorer

Sequential fitness scorer on the consuming end of the mul4_vector candidate interface. It drives operand limbs `a1,a0,b1,b0` into a combinational candidate multiplier and reads back the result limbs `y3..y0`. It compares each result against an internally computed golden product `{y3,y2,y1,y0} = {a1,a0} * {b1,b0}` (32×32 → 64, unsigned). It accumulates the count of correct result bits over a run of vectors, giving the tournament harness one fitness number per candidate.

## Interface
Parameters:
- `NUM_VECTORS`, default 256: vectors per run, ≥1.
- `SCORE_W`, default 15: score width, ≥ $clog2(64·NUM_VECTORS+1).
- `LFSR_SEED`, default 64'h1: LFSR load value. A value of 0 is replaced by 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin run. Sampled only in IDLE.
- `a1, a0, b1, b0` out 16 each: operand limbs to the candidate.
- `y3, y2, y1, y0` in 16 each: result limbs from the candidate.
- `busy` out 1: high from GEN through CMP.
- `done` out 1: one-cycle pulse at run end.
- `score` out SCORE_W: accumulated correct-bit count. Held after done.
- `vec_count` out $clog2(NUM_VECTORS+1): vectors completed.
- `perfect` out 1: `score == 64·NUM_VECTORS`. Updated at DONE.

## Operation
- FSM states:
  - IDLE: on `start`, go to GEN.
  - GEN: go to MUL.
  - MUL: 32 cycles, then CMP.
  - CMP: if `vec_count+1 == NUM_VECTORS`, go to DONE; otherwise go to GEN.
  - DONE: go to IDLE.
- On `start`:
  - LFSR reloads `LFSR_SEED`.
  - `score`, `vec_count` and `perfect` clear.
- GEN:
  - LFSR advances one step.
  - Operands register as `{a1,a0,b1,b0} = lfsr_next`.
- LFSR: 64-bit Galois, right-shift, mask 64'hD800_0000_0000_0000 (taps 64, 63, 61, 60).
  - If bit 0 of the state is 1: `next = (s>>1) ^ mask`.
  - Otherwise: `next = s>>1`.
- MUL: the shift-add unit computes the 64-bit golden product from the registered operands, one partial-product bit per cycle.
- CMP:
  - `score += popcount(~({y3,y2,y1,y0} ^ golden))`.
  - `vec_count += 1`.
- DONE:
  - `done = 1`.
  - `perfect` registers.
- `start` outside IDLE is ignored, including while in DONE.
- Operands hold from GEN until the next GEN. `y` is sampled only in CMP, so the candidate has ≥33 cycles to settle.
- `score` cannot overflow given the `SCORE_W` constraint. There is no saturation logic.
- Reset mid-run: all state returns to reset values immediately and the run is abandoned. The next `start` reproduces an identical run.
- Reset values: operands 0, `busy` 0, `done` 0, `score` 0, `vec_count` 0, `perfect` 0, FSM IDLE, LFSR = seed.

## Timing
- `start` sampled at edge E0. `busy` rises after E0.
- Each vector takes 34 edges: 1 GEN + 32 MUL + 1 CMP.
- `done` is high in the cycle following edge E0 + 34·NUM_VECTORS, for exactly one cycle. `busy` is low in that cycle.
- `score`, `vec_count` and `perfect` are stable from the `done` cycle until the next `start`.
- Back-to-back runs: `start` may be asserted in the cycle after `done`.

## Configuration
- `MUL4_SCORER_CORNER_EN`: corner-vector preamble.
  - Defined: the first min(4, NUM_VECTORS) GENs load fixed corners instead of advancing the LFSR:
    - (0, 0)
    - (FFFF_FFFF, FFFF_FFFF)
    - (FFFF_FFFF, 0000_0001)
    - (8000_0000, 0000_0002)
  - Defined: the LFSR first steps at vector 4. The total is still NUM_VECTORS.
  - Undefined: every vector comes from the LFSR. No corner logic is present.

## Structure
- Package `mul4_pkg` holds:
  - the FSM state enum;
  - the LFSR width and mask constants;
  - the MUL cycle count (32);
  - the four corner-vector constants;
  - the per-vector bit count (64).
- Sub-module `mul32_shift_add`: a `load` input, 32 cycles of iteration, then a `valid` pulse with a 64-bit product. Resets asynchronously on `rst_n`.
- Popcount and accumulation live in the top level.

## Test plan
- Ideal-multiplier candidate model, NUM_VECTORS=4, macro undefined, `start` pulse → `done` 136 cycles later, `score`=256, `perfect`=1, `vec_count`=4.
- LFSR_SEED=1, macro undefined → after the first GEN, `a1`=16'hD800 and `a0`=`b1`=`b0`=0. The golden product is 0, so a candidate tied to 0 scores 64 on vector 0.
- Macro defined, ideal candidate, NUM_VECTORS=2 → vector 1 golden = 64'hFFFF_FFFE_0000_0001, `score`=128.
- Candidate output `y3` bit 0 stuck at 1, corner vector 0 → vector 0 contributes 63. `perfect`=0.
- `start` re-pulsed mid-MUL → ignored. `done` timing and `score` are unchanged.
- `rst_n` asserted during MUL of vector 2 → all outputs 0 and `busy`=0 asynchronously. A new run gives a score identical to an uninterrupted run.
